wb_scoreboard_decoder: RTL and testbench

WB_SCOREBOARD_DECODER -- requirements
Module: wb_scoreboard_decoder

---
 rtl/wb_scoreboard_decoder.sv | 84 ++++++++
 tb/tb_wb_scoreboard_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard_decoder.sv
// Register scoreboard with a writeback decoder. It tracks pending writes per
// register, arbitrates issue against write-after-write hazards, and drives a
// registered one-hot register-file write enable.
module wb_scoreboard_decoder #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_ack,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    output logic [(1 << ADDR_W)-1:0]   wr_onehot,
    input  logic [ADDR_W-1:0]          rd1_addr,
    input  logic [ADDR_W-1:0]          rd2_addr,
    output logic                       rd1_busy,
    output logic                       rd2_busy,
    output logic [(1 << ADDR_W)-1:0]   busy,
    output logic                       err
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] wr_onehot_q, wr_onehot_d;
    logic            err_q, err_d;

    logic wr_zero, iss_zero, rd1_zero, rd2_zero;
    logic wb_fire;

    // Hazard checks, writeback bypass and next-state for all registered state.
    always_comb begin
        wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
        iss_zero = (ZERO_REG != 0) && (iss_addr == '0);
        rd1_zero = (ZERO_REG != 0) && (rd1_addr == '0);
        rd2_zero = (ZERO_REG != 0) && (rd2_addr == '0);

        wb_fire = en && wr_en && !wr_zero;

        // A same-cycle writeback to the target frees it, so the issue may proceed.
        // Reset is folded in so no acknowledgement escapes while rst is held.
        iss_ack = !rst && en && iss_en &&
                  (iss_zero || !busy_q[iss_addr] || (wb_fire && (wr_addr == iss_addr)));

        rd1_busy = !rst && !rd1_zero && busy_q[rd1_addr] &&
                   !(wb_fire && (wr_addr == rd1_addr));
        rd2_busy = !rst && !rd2_zero && busy_q[rd2_addr] &&
                   !(wb_fire && (wr_addr == rd2_addr));

        // Set has priority over clear when issue and writeback hit the same register.
        busy_d = busy_q;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (iss_ack && (iss_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                busy_d[i] = 1'b1;
            end else if (wb_fire && (wr_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end

        wr_onehot_d = wb_fire ? (NREG'(1) << wr_addr) : '0;
        err_d       = err_q || (wb_fire && !busy_q[wr_addr]);
    end

    // State update; a stall (en=0) leaves busy/err unchanged and empties wr_onehot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            wr_onehot_q <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            wr_onehot_q <= wr_onehot_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign wr_onehot = wr_onehot_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wb_scoreboard_decoder.sv
// Bench for wb_scoreboard_decoder: directed scenarios plus random traffic,
// checked against an array-based model of the scoreboard rules.
module tb_wb_scoreboard_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance: ADDR_W=4, ZERO_REG=1
    logic        en, iss_en, wr_en;
    logic [3:0]  iss_addr, wr_addr, rd1_addr, rd2_addr;
    logic        iss_ack, rd1_busy, rd2_busy, err;
    logic [15:0] wr_onehot, busy;

    // Small instance: ADDR_W=2, ZERO_REG=0
    logic        b_en, b_iss_en, b_wr_en;
    logic [1:0]  b_iss_addr, b_wr_addr, b_rd1_addr, b_rd2_addr;
    logic        b_iss_ack, b_rd1_busy, b_rd2_busy, b_err;
    logic [3:0]  b_wr_onehot, b_busy;

    wb_scoreboard_decoder #(.ADDR_W(4), .ZERO_REG(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ack   (iss_ack),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_onehot (wr_onehot),
        .rd1_addr  (rd1_addr),
        .rd2_addr  (rd2_addr),
        .rd1_busy  (rd1_busy),
        .rd2_busy  (rd2_busy),
        .busy      (busy),
        .err       (err)
    );

    wb_scoreboard_decoder #(.ADDR_W(2), .ZERO_REG(0)) u_dut_small (
        .clk       (clk),
        .rst       (rst),
        .en        (b_en),
        .iss_en    (b_iss_en),
        .iss_addr  (b_iss_addr),
        .iss_ack   (b_iss_ack),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_onehot (b_wr_onehot),
        .rd1_addr  (b_rd1_addr),
        .rd2_addr  (b_rd2_addr),
        .rd1_busy  (b_rd1_busy),
        .rd2_busy  (b_rd2_busy),
        .busy      (b_busy),
        .err       (b_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one flag per register, sticky error, last write enable
    bit          m_busy [16];
    bit          m_err;
    int unsigned m_oh;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 16; i++) if (m_busy[i]) v = v + (32'd1 << i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        m_err = 1'b0;
        m_oh  = 0;
    endtask

    // One cycle on the default instance: apply inputs after the rising edge,
    // check combinational outputs at the falling edge, registered ones after the next rise.
    task automatic step(input bit e, input bit ie, input int ia, input bit we, input int wa,
                        input int r1, input int r2);
        bit fire, ack, b1, b2;
        en = e; iss_en = ie; iss_addr = 4'(ia);
        wr_en = we; wr_addr = 4'(wa);
        rd1_addr = 4'(r1); rd2_addr = 4'(r2);
        @(negedge clk);
        fire = e && we && (wa != 0);
        ack  = e && ie && ((ia == 0) || !m_busy[ia] || (fire && wa == ia));
        b1   = (r1 != 0) && m_busy[r1] && !(fire && wa == r1);
        b2   = (r2 != 0) && m_busy[r2] && !(fire && wa == r2);
        check_eq("iss_ack", iss_ack, ack);
        check_eq("rd1_busy", rd1_busy, b1);
        check_eq("rd2_busy", rd2_busy, b2);
        if (fire) begin
            if (!m_busy[wa]) m_err = 1'b1;
            m_busy[wa] = 1'b0;
        end
        if (ack && ia != 0) m_busy[ia] = 1'b1;
        m_oh = fire ? (32'd1 << wa) : 0;
        @(posedge clk);
        #1;
        check_eq("busy", busy, model_vec());
        check_eq("wr_onehot", wr_onehot, m_oh);
        check_eq("err", err, m_err);
    endtask

    initial begin
        rst = 1'b1;
        en = 0; iss_en = 1; iss_addr = 4'd7; wr_en = 0; wr_addr = 0; rd1_addr = 0; rd2_addr = 0;
        b_en = 0; b_iss_en = 0; b_iss_addr = 0; b_wr_en = 0; b_wr_addr = 0;
        b_rd1_addr = 0; b_rd2_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        en = 1;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_onehot", wr_onehot, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_iss_ack", iss_ack, 0);
        check_eq("rst_small_busy", b_busy, 0);
        en = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Decode sweep over 1..15, then a writeback to the hard-wired register
        for (int a = 1; a < 16; a++) begin
            step(1, 1, a, 0, 0, a, 0);
            step(1, 0, 0, 1, a, a, 0);
        end
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);

        // WAW: re-issue rejected, issue alongside writeback accepted
        step(1, 1, 5, 0, 0, 5, 0);
        step(1, 1, 5, 0, 0, 5, 0);
        step(1, 1, 5, 1, 5, 5, 0);
        check_eq("waw_busy", busy, 32'h0020);
        step(1, 0, 0, 1, 5, 0, 0);

        // Stall holds state and suppresses the bypass; advance enables it
        step(1, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 3, 3);
        check_eq("stall_busy", busy, 32'h0008);
        step(1, 0, 0, 1, 3, 3, 3);

        // Writeback to an idle register raises a sticky error
        step(1, 0, 0, 1, 9, 0, 0);
        step(1, 1, 2, 0, 0, 2, 9);
        step(1, 0, 0, 1, 2, 2, 0);
        check_eq("err_sticky", err, 1);

        // Build busy 0x8420 with a live write enable, then reset between edges
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 1, 10, 0, 0, 0, 0);
        step(1, 1, 15, 1, 9, 0, 0);
        check_eq("pre_rst_busy", busy, 32'h8420);
        en = 1; iss_en = 1; iss_addr = 4'd15; wr_en = 0; rd1_addr = 4'd15; rd2_addr = 4'd10;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_onehot", wr_onehot, 0);
        check_eq("arst_err", err, 0);
        check_eq("arst_iss_ack", iss_ack, 0);
        check_eq("arst_rd1_busy", rd1_busy, 0);
        en = 0;
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 1, 15, 0, 0, 15, 0);

        // Random traffic over a narrow address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        // Small instance: register 0 is an ordinary register
        b_en = 1; b_iss_en = 1; b_iss_addr = 0; b_rd1_addr = 0;
        @(negedge clk);
        check_eq("r0_iss_ack", b_iss_ack, 1);
        @(posedge clk);
        #1;
        check_eq("r0_busy_set", b_busy, 4'b0001);
        check_eq("r0_rd1_busy", b_rd1_busy, 1);
        b_iss_en = 0; b_wr_en = 1; b_wr_addr = 0;
        @(negedge clk);
        check_eq("r0_bypass", b_rd1_busy, 0);
        @(posedge clk);
        #1;
        check_eq("r0_busy_clr", b_busy, 4'b0000);
        check_eq("r0_onehot", b_wr_onehot, 4'b0001);
        check_eq("r0_err", b_err, 0);
        b_wr_en = 0;
        @(posedge clk);
        #1;
        check_eq("r0_onehot_idle", b_wr_onehot, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
